channel_select_seq: RTL and testbench

- Channel-side sequencer that drives Parallel Channel "A" through one initial-selection sequence: address out, command out, initial status in, service out accept.
- Used by a host to exercise a control unit (mock or real) over bus-and-tag.
- Software or a test harness starts it with a device address and command byte, and gets back the initial status byte or an error code.
- Sits alongside the mock control unit on the same clock and replaces manual tag wiggling.

---
 rtl/channel_pkg.sv | 30 +++
 rtl/channel_select_seq_if.sv | 38 +++
 rtl/channel_in_sync.sv | 33 +++
 rtl/channel_select_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_channel_select_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_pkg.sv
// Shared types for the channel-A selection sequencer: FSM states, result codes, bus parity.
package channel_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_SELECT,
        ST_WAIT_ADDR_IN,
        ST_CMD_SETUP,
        ST_WAIT_ADDR_DROP,
        ST_WAIT_STATUS,
        ST_WAIT_STATUS_DROP,
        ST_FINISH,
        ST_ERROR
    } seq_state_e;

    typedef enum logic [2:0] {
        RESULT_OK            = 3'd0,
        RESULT_TIMEOUT       = 3'd1,
        RESULT_NO_DEVICE     = 3'd2,
        RESULT_ADDR_MISMATCH = 3'd3,
        RESULT_PARITY        = 3'd4
    } result_e;

    // Bit that makes the 9-bit bus+parity word carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/channel_select_seq_if.sv
// Parallel channel "A" bus-and-tag bundle; master = channel side, slave = control unit side.
interface channel_select_seq_if;
    logic [7:0] a_bus_out;
    logic       a_bus_out_parity;
    logic [7:0] a_bus_in;
    logic       a_bus_in_parity;
    logic       a_operational_out;
    logic       a_hold_out;
    logic       a_select_out;
    logic       a_address_out;
    logic       a_command_out;
    logic       a_service_out;
    logic       a_suppress_out;
    logic       a_operational_in;
    logic       a_address_in;
    logic       a_status_in;
    logic       a_service_in;
    logic       a_select_in;
    logic       a_request_in;

    modport master (
        output a_bus_out, a_bus_out_parity,
        output a_operational_out, a_hold_out, a_select_out, a_address_out,
        output a_command_out, a_service_out, a_suppress_out,
        input  a_bus_in, a_bus_in_parity,
        input  a_operational_in, a_address_in, a_status_in, a_service_in,
        input  a_select_in, a_request_in
    );

    modport slave (
        input  a_bus_out, a_bus_out_parity,
        input  a_operational_out, a_hold_out, a_select_out, a_address_out,
        input  a_command_out, a_service_out, a_suppress_out,
        output a_bus_in, a_bus_in_parity,
        output a_operational_in, a_address_in, a_status_in, a_service_in,
        output a_select_in, a_request_in
    );
endinterface

// File: rtl/channel_in_sync.sv
// Multi-stage flop chain bringing channel tag-in/bus-in into the aclk domain.
// Latency STAGES cycles; no backpressure, samples every cycle.
module channel_in_sync #(
    parameter int WIDTH  = 13,
    parameter int STAGES = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];
endmodule

// File: rtl/channel_select_seq.sv
// Channel-side initial-selection sequencer: address out, command out, status in, service accept.
// Latency is set by control-unit response plus deskew; start is dropped while busy, no queueing.
module channel_select_seq
    import channel_pkg::*;
#(
    parameter int DESKEW_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [7:0]           device_addr,
    input  logic [7:0]           command,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           result,
    output logic [7:0]           status,
    channel_select_seq_if.master ch
);
    localparam int SW = 13;
    localparam logic [15:0] DS_LAST = 16'(DESKEW_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    seq_state_e state_q, state_d;
    result_e    result_q, result_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d, cmd_q, cmd_d, status_q, status_d, bus_q, bus_d;
    logic op_q, op_d, hold_q, hold_d, select_q, select_d;
    logic address_q, address_d, command_q, command_d, service_q, service_d;

    logic [SW-1:0] sync_in, sync_out;
    logic [7:0] s_bus;
    logic s_par, s_sel, s_sts, s_adr, s_opr, par_ok;
    logic accept, fail, timed_out;
    result_e fail_code;
    logic unused_tags;

    assign sync_in = {ch.a_bus_in_parity, ch.a_bus_in, ch.a_select_in,
                      ch.a_status_in, ch.a_address_in, ch.a_operational_in};

    channel_in_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_in_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (sync_in),
        .dout    (sync_out)
    );

    assign {s_par, s_bus, s_sel, s_sts, s_adr, s_opr} = sync_out;
    assign par_ok      = (odd_parity(s_bus) == s_par);
    assign timed_out   = (cnt_q >= TO_LAST);
    assign unused_tags = ch.a_request_in ^ ch.a_service_in;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        status_d  = status_q;
        bus_d     = bus_q;
        op_d      = 1'b1;
        hold_d    = hold_q;
        select_d  = select_q;
        address_d = address_q;
        command_d = command_q;
        service_d = service_q;
        accept    = 1'b0;
        fail      = 1'b0;
        fail_code = RESULT_OK;

        case (state_q)
            ST_IDLE: accept = start;
            ST_ADDR_SETUP: begin
                if (cnt_q >= DS_LAST) begin
                    address_d = 1'b1;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                hold_d   = 1'b1;
                select_d = 1'b1;
                if (s_sel) begin
                    fail      = 1'b1;
                    fail_code = RESULT_NO_DEVICE;
                end else if (s_opr) begin
                    hold_d   = 1'b0;
                    select_d = 1'b0;
                    state_d  = ST_WAIT_ADDR_IN;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = RESULT_TIMEOUT;
                end
            end
            ST_WAIT_ADDR_IN: begin
                if (s_adr) begin
                    if (!par_ok) begin
                        fail      = 1'b1;
                        fail_code = RESULT_PARITY;
                    end else if (s_bus != addr_q) begin
                        fail      = 1'b1;
                        fail_code = RESULT_ADDR_MISMATCH;
                    end else begin
                        address_d = 1'b0;
                        bus_d     = cmd_q;
                        state_d   = ST_CMD_SETUP;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = RESULT_TIMEOUT;
                end
            end
            ST_CMD_SETUP: begin
                if (cnt_q >= DS_LAST) begin
                    command_d = 1'b1;
                    state_d   = ST_WAIT_ADDR_DROP;
                end
            end
            ST_WAIT_ADDR_DROP: begin
                if (!s_adr) begin
                    command_d = 1'b0;
                    state_d   = ST_WAIT_STATUS;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = RESULT_TIMEOUT;
                end
            end
            ST_WAIT_STATUS: begin
                if (s_sts) begin
                    if (!par_ok) begin
                        fail      = 1'b1;
                        fail_code = RESULT_PARITY;
                    end else begin
                        status_d  = s_bus;
                        service_d = 1'b1;
                        state_d   = ST_WAIT_STATUS_DROP;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = RESULT_TIMEOUT;
                end
            end
            ST_WAIT_STATUS_DROP: begin
                if (!s_sts) begin
                    service_d = 1'b0;
                    bus_d     = 8'h00;
                    result_d  = RESULT_OK;
                    state_d   = ST_FINISH;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = RESULT_TIMEOUT;
                end
            end
            // Done cycle; busy is already low, so a fresh start may launch directly.
            ST_FINISH, ST_ERROR: begin
                state_d = ST_IDLE;
                accept  = start;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            addr_d  = device_addr;
            cmd_d   = command;
            bus_d   = device_addr;
            state_d = ST_ADDR_SETUP;
        end

        if (fail) begin
            hold_d    = 1'b0;
            select_d  = 1'b0;
            address_d = 1'b0;
            command_d = 1'b0;
            service_d = 1'b0;
            bus_d     = 8'h00;
            result_d  = fail_code;
            state_d   = ST_ERROR;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            result_q  <= RESULT_OK;
            cnt_q     <= '0;
            addr_q    <= '0;
            cmd_q     <= '0;
            status_q  <= '0;
            bus_q     <= '0;
            op_q      <= 1'b0;
            hold_q    <= 1'b0;
            select_q  <= 1'b0;
            address_q <= 1'b0;
            command_q <= 1'b0;
            service_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            status_q  <= status_d;
            bus_q     <= bus_d;
            op_q      <= op_d;
            hold_q    <= hold_d;
            select_q  <= select_d;
            address_q <= address_d;
            command_q <= command_d;
            service_q <= service_d;
        end
    end

    assign busy   = !(state_q inside {ST_IDLE, ST_FINISH, ST_ERROR});
    assign done   = (state_q == ST_FINISH) || (state_q == ST_ERROR);
    assign result = result_q;
    assign status = status_q;

    assign ch.a_bus_out         = bus_q;
    assign ch.a_bus_out_parity  = odd_parity(bus_q);
    assign ch.a_operational_out = op_q;
    assign ch.a_hold_out        = hold_q;
    assign ch.a_select_out      = select_q;
    assign ch.a_address_out     = address_q;
    assign ch.a_command_out     = command_q;
    assign ch.a_service_out     = service_q;
    assign ch.a_suppress_out    = 1'b0;
endmodule

// File: tb/tb_channel_select_seq.sv
// Bench for channel_select_seq: mock control unit, tag monitor and result/status scoreboard.
module tb_channel_select_seq;
    localparam int M_OK = 0, M_NODEV = 1, M_MISMATCH = 2, M_BADPAR = 3, M_NOSTS = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic [7:0] device_addr = 8'h00;
    logic [7:0] command = 8'h00;
    logic busy, done;
    logic [2:0] result;
    logic [7:0] status;

    channel_select_seq_if ch();

    always #5 aclk = ~aclk;

    channel_select_seq #(.DESKEW_CYCLES(4), .TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .device_addr(device_addr),
        .command(command), .busy(busy), .done(done), .result(result), .status(status), .ch(ch)
    );

    int checks = 0;
    int failures = 0;
    int cu_mode = M_OK;
    logic [7:0] cu_status = 8'h00;
    logic [7:0] model_status = 8'h00;
    logic [10:0] exp_q[$];

    int cyc = 0;
    int tag_code = 0, addr_lead = 0, cmd_lead = 0, cmd_fall_cyc = 0, done_cnt = 0, done_at = 0;
    logic [7:0] addr_seen = 8'h00, cmd_seen = 8'h00, bus_at_done = 8'h00;
    logic [5:0] tags_at_done = 6'h00;
    logic op_at_done = 1'b0, busy_at_done = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic clear_cu();
        ch.a_bus_in = 8'h00; ch.a_bus_in_parity = 1'b1;
        ch.a_operational_in = 1'b0; ch.a_address_in = 1'b0; ch.a_status_in = 1'b0;
        ch.a_service_in = 1'b0; ch.a_select_in = 1'b0; ch.a_request_in = 1'b0;
    endtask

    // Mock control unit: reacts to tags-out on the falling edge.
    initial begin : mock_cu
        int st;
        logic [7:0] reply;
        st = 0;
        clear_cu();
        forever begin
            @(negedge aclk);
            if (!aresetn || !busy) begin
                clear_cu();
                st = 0;
            end else begin
                case (st)
                    0: if (ch.a_select_out && ch.a_hold_out) begin
                        if (cu_mode == M_NODEV) begin
                            ch.a_select_in = 1'b1;
                        end else begin
                            reply = ch.a_bus_out;
                            if (cu_mode == M_MISMATCH || cu_mode == M_BADPAR) reply = reply + 8'd1;
                            ch.a_bus_in = reply;
                            ch.a_bus_in_parity = (cu_mode == M_BADPAR) ? (^reply) : ~(^reply);
                            ch.a_operational_in = 1'b1;
                            ch.a_address_in = 1'b1;
                        end
                        st = 1;
                    end
                    1: if (ch.a_command_out) begin
                        ch.a_address_in = 1'b0;
                        st = 2;
                    end
                    2: if (!ch.a_command_out && cu_mode != M_NOSTS) begin
                        ch.a_bus_in = cu_status;
                        ch.a_bus_in_parity = ~(^cu_status);
                        ch.a_status_in = 1'b1;
                        st = 3;
                    end
                    3: if (ch.a_service_out) begin
                        ch.a_status_in = 1'b0;
                        ch.a_bus_in = 8'h00;
                        ch.a_bus_in_parity = 1'b1;
                        st = 4;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tag-out monitor: rise order, bus stability ahead of strobes, done count.
    initial begin : monitor
        logic [7:0] prev_bus;
        int stable;
        logic p_adr, p_hs, p_cmd, p_svc;
        prev_bus = 8'h00; stable = 0;
        p_adr = 1'b0; p_hs = 1'b0; p_cmd = 1'b0; p_svc = 1'b0;
        forever begin
            @(negedge aclk);
            if (ch.a_bus_out === prev_bus) stable++; else stable = 1;
            prev_bus = ch.a_bus_out;
            if (ch.a_address_out && !p_adr) begin
                tag_code = tag_code * 10 + 1; addr_lead = stable - 1; addr_seen = ch.a_bus_out;
            end
            if (ch.a_hold_out && ch.a_select_out && !p_hs) tag_code = tag_code * 10 + 2;
            if (ch.a_command_out && !p_cmd) begin
                tag_code = tag_code * 10 + 3; cmd_lead = stable - 1; cmd_seen = ch.a_bus_out;
            end
            if (!ch.a_command_out && p_cmd) cmd_fall_cyc = cyc;
            if (ch.a_service_out && !p_svc) tag_code = tag_code * 10 + 4;
            if (done) done_cnt++;
            p_adr = ch.a_address_out; p_hs = ch.a_hold_out && ch.a_select_out;
            p_cmd = ch.a_command_out; p_svc = ch.a_service_out;
        end
    end

    task automatic run_txn(input logic [7:0] a, input logic [7:0] c, input logic [2:0] er,
                           input logic [7:0] es, input string nm);
        logic [10:0] exp;
        int waited;
        if (er == 3'd0) model_status = es;
        exp_q.push_back({er, model_status});
        @(negedge aclk);
        tag_code = 0;
        device_addr = a; command = c; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 300) begin
            @(negedge aclk);
            waited++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s done_wait: got no done after %0d cycles, required done=1", nm, waited);
            void'(exp_q.pop_front());
        end else begin
            done_at = cyc;
            bus_at_done = ch.a_bus_out;
            op_at_done = ch.a_operational_out;
            busy_at_done = busy;
            tags_at_done = {ch.a_hold_out, ch.a_select_out, ch.a_address_out,
                            ch.a_command_out, ch.a_service_out, ch.a_suppress_out};
            exp = exp_q.pop_front();
            checks++;
            if (result !== exp[10:8]) begin
                failures++;
                $display("FAIL %s result: got %0d, required %0d", nm, result, exp[10:8]);
            end
            checks++;
            if (status !== exp[7:0]) begin
                failures++;
                $display("FAIL %s status: got %02h, required %02h", nm, status, exp[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, result, status, ch.a_bus_out, ch.a_operational_out, ch.a_hold_out,
             ch.a_select_out, ch.a_address_out, ch.a_command_out, ch.a_service_out,
             ch.a_suppress_out} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%0d status=%02h bus=%02h op=%b, required all 0",
                     busy, done, result, status, ch.a_bus_out, ch.a_operational_out);
        end
        checks++;
        if (ch.a_bus_out_parity !== 1'b1) begin
            failures++;
            $display("FAIL reset_parity: got %b, required 1", ch.a_bus_out_parity);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (ch.a_operational_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_op_out: got %b, required 1", ch.a_operational_out);
        end
    endtask

    task automatic test_happy();
        cu_mode = M_OK; cu_status = 8'h08;
        run_txn(8'hE0, 8'h02, 3'd0, 8'h08, "happy");
        checks++;
        if (tag_code !== 1234) begin
            failures++;
            $display("FAIL happy_tag_order: got %0d, required 1234", tag_code);
        end
        checks++;
        if (addr_lead < 4 || cmd_lead < 4) begin
            failures++;
            $display("FAIL happy_deskew: got addr_lead=%0d cmd_lead=%0d, required >=4", addr_lead, cmd_lead);
        end
        checks++;
        if (addr_seen !== 8'hE0 || cmd_seen !== 8'h02) begin
            failures++;
            $display("FAIL happy_bus: got addr=%02h cmd=%02h, required E0/02", addr_seen, cmd_seen);
        end
        checks++;
        if (bus_at_done !== 8'h00 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL happy_idle: got bus=%02h busy=%b, required 00/0", bus_at_done, busy_at_done);
        end
    endtask

    task automatic test_parity_out();
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            b = ch.a_bus_out;
            if (ch.a_command_out || ch.a_address_out) begin
                checks++;
                if (ch.a_bus_out_parity !== ~(^b)) begin
                    failures++;
                    $display("FAIL bus_out_parity: got %b for %02h, required %b", ch.a_bus_out_parity, b, ~(^b));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        cu_mode = M_OK;
        cu_status = 8'h4E;
        run_txn(8'h5A, 8'hC3, 3'd0, 8'h4E, "b2b_first");
        cu_status = 8'h00;
        run_txn(8'h01, 8'hFF, 3'd0, 8'h00, "b2b_second");
    endtask

    task automatic test_no_device();
        cu_mode = M_NODEV;
        run_txn(8'h33, 8'h04, 3'd2, 8'h00, "no_device");
        checks++;
        if (tags_at_done !== 6'd0 || op_at_done !== 1'b1 || busy_at_done !== 1'b0 || bus_at_done !== 8'h00) begin
            failures++;
            $display("FAIL no_device_tags: got tags=%06b op=%b busy=%b bus=%02h, required 000000/1/0/00",
                     tags_at_done, op_at_done, busy_at_done, bus_at_done);
        end
    endtask

    task automatic test_addr_errors();
        cu_mode = M_MISMATCH;
        run_txn(8'hE0, 8'h02, 3'd3, 8'h00, "addr_mismatch");
        cu_mode = M_BADPAR;
        run_txn(8'hE0, 8'h02, 3'd4, 8'h00, "addr_parity");
    endtask

    task automatic test_timeout();
        cu_mode = M_NOSTS;
        run_txn(8'h21, 8'h0C, 3'd1, 8'h00, "timeout");
        checks++;
        if (done_at - cmd_fall_cyc !== 16) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, required 16", done_at - cmd_fall_cyc);
        end
        checks++;
        if (tags_at_done[2] !== 1'b0 || bus_at_done !== 8'h00) begin
            failures++;
            $display("FAIL timeout_outputs: got cmd_out=%b bus=%02h, required 0/00", tags_at_done[2], bus_at_done);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        cu_mode = M_NOSTS;
        @(negedge aclk);
        device_addr = 8'h47; command = 8'h09; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        waited = 0;
        while (!ch.a_command_out && waited < 200) begin @(negedge aclk); waited++; end
        while (ch.a_command_out && waited < 200) begin @(negedge aclk); waited++; end
        checks++;
        if (waited >= 200) begin
            failures++;
            $display("FAIL reset_mid_reach: got no WAIT_STATUS entry in %0d cycles, required entry", waited);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, status, ch.a_bus_out, ch.a_operational_out, ch.a_hold_out,
             ch.a_select_out, ch.a_address_out, ch.a_command_out, ch.a_service_out} !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got busy=%b bus=%02h op=%b result=%0d, required all 0",
                     busy, ch.a_bus_out, ch.a_operational_out, result);
        end
        model_status = 8'h00;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (ch.a_operational_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_op: got %b, required 1", ch.a_operational_out);
        end
        cu_mode = M_OK; cu_status = 8'h0C;
        run_txn(8'h47, 8'h09, 3'd0, 8'h0C, "after_reset");
    endtask

    task automatic test_start_busy();
        int base;
        logic [10:0] exp;
        int waited;
        cu_mode = M_OK; cu_status = 8'h91;
        model_status = 8'h91;
        exp_q.push_back({3'd0, 8'h91});
        base = done_cnt;
        @(negedge aclk);
        device_addr = 8'h3C; command = 8'h11; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (8) @(negedge aclk);
        device_addr = 8'h99; command = 8'h77; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 300) begin @(negedge aclk); waited++; end
        exp = exp_q.pop_front();
        checks++;
        if (!done || result !== exp[10:8] || status !== exp[7:0]) begin
            failures++;
            $display("FAIL busy_start_result: got done=%b result=%0d status=%02h, required 1/%0d/%02h",
                     done, result, status, exp[10:8], exp[7:0]);
        end
        checks++;
        if (addr_seen !== 8'h3C || cmd_seen !== 8'h11) begin
            failures++;
            $display("FAIL busy_start_latch: got addr=%02h cmd=%02h, required 3C/11", addr_seen, cmd_seen);
        end
        repeat (60) @(negedge aclk);
        checks++;
        if (done_cnt - base !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_count: got %0d dones busy=%b, required 1 done busy=0", done_cnt - base, busy);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        fork
            test_happy();
            test_parity_out();
        join
        test_back_to_back();
        test_no_device();
        test_addr_errors();
        test_timeout();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
